// File: rtl/dlx_alu_sequencer.sv
// dlx_alu_sequencer: issue controller between decode and the DLX execute-stage ALU.
// Latency: accept -> out_valid in ALU_LATENCY+2 edges (legal), 1 edge (illegal).
// Backpressure: in_ready only in IDLE; out_valid/data held stable until out_ready.
// Ports: clk/reset (sync, active-low); in_* decode side (valid/ready);
//        alu_* ALU issue/result; out_* writeback side (valid/ready); op_count.
module dlx_alu_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_op_a,
  input  logic [31:0] in_op_b,
  output logic        alu_enable,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_operation,
  output logic [2:0]  alu_opselect,
  input  logic [32:0] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_carry,
  output logic [4:0]  out_rd,
  output logic        out_err,
  output logic [15:0] op_count
);

  localparam logic [2:0] SEL_ARITH = 3'b001;
  localparam logic [2:0] SEL_MEMRD = 3'b101;
  localparam logic [2:0] CNT_INIT  = 3'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [31:0] in1_q, in2_q, result_q;
  logic [2:0]  operation_q, opselect_q;
  logic [4:0]  rd_q;
  logic        err_q, carry_q;
  logic [15:0] op_count_q;

  // Instruction field decode
  logic [2:0]  f_opselect, f_operation;
  logic        f_imm_sel, f_legal;
  logic [31:0] f_in2;
  logic        unused_bits;

  assign f_opselect  = in_instr[31:29];
  assign f_operation = in_instr[28:26];
  assign f_imm_sel   = in_instr[25];
  assign unused_bits = ^in_instr[24:21];

  always_comb begin
    f_legal = 1'b0;
    if (f_opselect == SEL_ARITH) begin
      f_legal = 1'b1;
    end else if (f_opselect == SEL_MEMRD) begin
      case (f_operation)
        3'b000, 3'b100, 3'b001, 3'b101, 3'b011: f_legal = 1'b1;
        default:                                f_legal = 1'b0;
      endcase
    end
  end

  // Memory reads always take op_b (read data); only ALU ops may use the immediate.
  assign f_in2 = (f_opselect == SEL_ARITH && f_imm_sel) ?
                 {{16{in_instr[15]}}, in_instr[15:0]} : in_op_b;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = f_legal ? ISSUE : DONE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (cnt == 3'd0) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= 3'd0;
      in1_q       <= 32'd0;
      in2_q       <= 32'd0;
      operation_q <= 3'd0;
      opselect_q  <= 3'd0;
      rd_q        <= 5'd0;
      err_q       <= 1'b0;
      result_q    <= 32'd0;
      carry_q     <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in1_q       <= in_op_a;
            in2_q       <= f_in2;
            operation_q <= f_operation;
            opselect_q  <= f_opselect;
            rd_q        <= in_instr[20:16];
            err_q       <= ~f_legal;
            // Cleared here so an illegal op reports a zero result.
            result_q    <= 32'd0;
            carry_q     <= 1'b0;
          end
        end
        ISSUE: cnt <= CNT_INIT;
        WAIT: begin
          if (cnt == 3'd0) begin
            result_q <= alu_out[31:0];
            carry_q  <= alu_out[32];
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          if (out_ready && !err_q) op_count_q <= op_count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    logic hold, done;
    hold          = (state == ISSUE) || (state == WAIT);
    done          = (state == DONE);
    in_ready      = (state == IDLE);
    alu_enable    = (state == ISSUE);
    alu_in1       = hold ? in1_q : 32'd0;
    alu_in2       = hold ? in2_q : 32'd0;
    alu_operation = hold ? operation_q : 3'd0;
    alu_opselect  = hold ? opselect_q : 3'd0;
    out_valid     = done;
    out_result    = done ? result_q : 32'd0;
    out_carry     = done ? carry_q : 1'b0;
    out_rd        = done ? rd_q : 5'd0;
    out_err       = done ? err_q : 1'b0;
    op_count      = op_count_q;
  end

endmodule

// File: tb/tb_dlx_alu_sequencer.sv
module tb_dlx_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_op_a = '0;
  logic [31:0] in_op_b = '0;
  logic        alu_enable;
  logic [31:0] alu_in1, alu_in2;
  logic [2:0]  alu_operation, alu_opselect;
  logic [32:0] alu_out = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_carry;
  logic [4:0]  out_rd;
  logic        out_err;
  logic [15:0] op_count;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  logic [31:0] last_in2 = '0;
  int model_cnt = 0;
  logic [31:0] got_res;
  logic        got_c;

  dlx_alu_sequencer #(.ALU_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_op_a(in_op_a), .in_op_b(in_op_b),
    .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_operation(alu_operation), .alu_opselect(alu_opselect), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_rd(out_rd), .out_err(out_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU function (bench-defined operation encoding).
  function automatic logic [32:0] alu_ref(input logic [2:0] sel, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [16:0] h;
    alu_ref = 33'd0;
    if (sel == 3'b001) begin
      case (op)
        3'b000: alu_ref = {1'b0, a} + {1'b0, b};
        3'b001: begin h = {1'b0, a[15:0]} + {1'b0, b[15:0]}; alu_ref = {h[16], 16'h0, h[15:0]}; end
        3'b010: alu_ref = {1'b0, a} - {1'b0, b};
        3'b011: alu_ref = {1'b0, a & b};
        3'b100: alu_ref = {1'b0, a | b};
        3'b101: alu_ref = {1'b0, a ^ b};
        3'b110: alu_ref = {1'b0, ~a};
        default: alu_ref = {1'b0, b[15:0], 16'h0};
      endcase
    end else if (sel == 3'b101) begin
      case (op)
        3'b000: alu_ref = {{25{b[7]}}, b[7:0]};
        3'b100: alu_ref = {25'd0, b[7:0]};
        3'b001: alu_ref = {{17{b[15]}}, b[15:0]};
        3'b101: alu_ref = {17'd0, b[15:0]};
        default: alu_ref = {1'b0, b};
      endcase
    end
  endfunction

  // ALU model: result valid only in the cycle after the enable edge, noise otherwise,
  // so a capture on the wrong cycle is visible.
  always @(posedge clk) begin
    if (alu_enable) begin
      alu_out  <= alu_ref(alu_opselect, alu_operation, alu_in1, alu_in2);
      last_in2 <= alu_in2;
      en_cnt   <= en_cnt + 1;
    end else begin
      alu_out  <= {1'($urandom), 32'($urandom)};
    end
  end

  function automatic logic [31:0] mk(input logic [2:0] sel, input logic [2:0] op,
                                     input logic imm_sel, input logic [4:0] rd,
                                     input logic [15:0] imm);
    mk = {sel, op, imm_sel, 4'b0000, rd, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, latency, result, optional backpressure, handshake.
  task automatic run_op(input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [2:0]  sel, op;
    logic        legal;
    logic [31:0] exp_in2, res0;
    logic [32:0] exp;
    int          n, en0;
    sel = instr[31:29];
    op  = instr[28:26];
    legal = (sel == 3'b001) || (sel == 3'b101 && op inside {3'b000, 3'b100, 3'b001, 3'b101, 3'b011});
    exp_in2 = (sel == 3'b001 && instr[25]) ? {{16{instr[15]}}, instr[15:0]} : b;
    exp = legal ? alu_ref(sel, op, a, exp_in2) : 33'd0;

    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    en0 = en_cnt;
    in_valid = 1'b1; in_instr = instr; in_op_a = a; in_op_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), legal ? 64'd3 : 64'd1);
    chk("enable_pulses", 64'(en_cnt - en0), legal ? 64'd1 : 64'd0);
    if (legal) chk("alu_in2", 64'(last_in2), 64'(exp_in2));
    chk("result", 64'(out_result), 64'(exp[31:0]));
    chk("carry", 64'(out_carry), 64'(exp[32]));
    chk("rd", 64'(out_rd), 64'(instr[20:16]));
    chk("err", 64'(out_err), legal ? 64'd0 : 64'd1);
    got_res = out_result;
    got_c   = out_carry;
    res0    = out_result;

    // A new request is offered while the result is pending; it must be ignored.
    in_valid = 1'b1; in_instr = mk(3'b001, 3'b000, 1'b0, 5'd1, 16'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(out_result), 64'(res0));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (legal) model_cnt = (model_cnt + 1) % 65536;
    chk("op_count", 64'(op_count), 64'(model_cnt));
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("no_accept_in_done", 64'(in_ready), 64'd1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_alu_enable"}, 64'(alu_enable), 64'd0);
    chk({tag, "_op_count"}, 64'(op_count), 64'd0);
    chk({tag, "_outs"}, {out_result, out_carry, out_err, out_rd}, 64'd0);
    chk({tag, "_alu_ins"}, {alu_in1, alu_in2}, 64'd0);
  endtask

  initial begin
    int n;
    int en0;
    logic [2:0] sel;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    reset = 1'b1;

    // ADD 5+7
    run_op(mk(3'b001, 3'b000, 1'b0, 5'd3, 16'd0), 32'd5, 32'd7, 0);
    chk("add_val", {got_c, got_res}, 64'd12);
    chk("add_count", 64'(op_count), 64'd1);
    // SUB 3-5
    run_op(mk(3'b001, 3'b010, 1'b0, 5'd4, 16'd0), 32'd3, 32'd5, 1);
    chk("sub_val", {got_c, got_res}, {31'd0, 1'b1, 32'hFFFF_FFFE});
    // HADD FFFF+0001
    run_op(mk(3'b001, 3'b001, 1'b0, 5'd5, 16'd0), 32'h0000_FFFF, 32'h0000_0001, 0);
    chk("hadd_val", {got_c, got_res}, {31'd0, 1'b1, 32'h0});
    // LHG with immediate
    run_op(mk(3'b001, 3'b111, 1'b1, 5'd6, 16'h1234), 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);
    chk("lhg_val", 64'(got_res), 64'h1234_0000);
    chk("lhg_in2", 64'(last_in2), 64'h0000_1234);
    // LOADBYTE / LOADBYTEU (imm_sel ignored for memory reads)
    run_op(mk(3'b101, 3'b000, 1'b1, 5'd7, 16'h7777), 32'd0, 32'h80, 0);
    chk("lb_val", 64'(got_res), 64'hFFFF_FF80);
    run_op(mk(3'b101, 3'b100, 1'b0, 5'd8, 16'd0), 32'd0, 32'h80, 0);
    chk("lbu_val", 64'(got_res), 64'h80);
    // Illegal opselect and illegal memory operation
    run_op(mk(3'b000, 3'b000, 1'b0, 5'd9, 16'd0), 32'd1, 32'd2, 0);
    run_op(mk(3'b101, 3'b010, 1'b0, 5'd10, 16'd0), 32'd1, 32'd2, 0);
    chk("illegal_count", 64'(op_count), 64'd6);
    // Backpressure for 5 cycles
    run_op(mk(3'b001, 3'b000, 1'b0, 5'd11, 16'd0), 32'd100, 32'd23, 5);
    chk("bp_add_val", 64'(got_res), 64'd123);

    // Randomized ops against the reference model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    sel = 3'b001;
        2:       sel = 3'b101;
        default: sel = 3'($urandom);
      endcase
      run_op(mk(sel, 3'($urandom), 1'($urandom), 5'($urandom), 16'($urandom)),
             32'($urandom), 32'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset during WAIT
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk(3'b001, 3'b000, 1'b0, 5'd2, 16'd0);
    in_op_a = 32'd9; in_op_b = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    en0 = en_cnt;
    @(negedge clk);
    reset = 1'b1;
    reset_checks("rst_wait");
    repeat (3) @(negedge clk);
    chk("rst_wait_no_valid", 64'(out_valid), 64'd0);
    chk("rst_wait_no_enable", 64'(en_cnt - en0), 64'd0);
    model_cnt = 0;

    run_op(mk(3'b001, 3'b000, 1'b0, 5'd12, 16'd0), 32'd2, 32'd2, 0);

    // Reset during DONE
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk(3'b001, 3'b000, 1'b0, 5'd13, 16'd0);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_done_reached", 64'(out_valid), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    reset_checks("rst_done");
    model_cnt = 0;

    run_op(mk(3'b001, 3'b000, 1'b0, 5'd14, 16'd0), 32'd1, 32'd1, 0);
    chk("after_reset_add", {got_c, got_res}, 64'd2);
    chk("after_reset_count", 64'(op_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
